// File: rtl/drop_sequencer.sv
// Game-flow controller for the falling piece: spawn, game-over check, timed
// gravity, collision probe, lock and line clear. All outputs are registered.
module drop_sequencer #(
  parameter logic [3:0]  SPAWN_X    = 4'd3,
  parameter logic [4:0]  SPAWN_Y    = 5'd0,
  parameter logic [15:0] BASE_TICKS = 16'd1000,
  parameter logic [15:0] LEVEL_STEP = 16'd60,
  parameter logic [15:0] MIN_TICKS  = 16'd100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       tick,
  input  logic [3:0] level,
  input  logic       soft_drop,
  input  logic       x_load,
  input  logic [3:0] x_new,
  input  logic       game_over_in,
  output logic       fit_req,
  output logic [4:0] fit_y,
  input  logic       fit_ack,
  input  logic       fit_ok,
  input  logic       clear_done,
  output logic [3:0] pos_x,
  output logic [4:0] pos_y,
  output logic       new_game,
  output logic       spawn,
  output logic       lock,
  output logic       clear_req,
  output logic [2:0] state,
  output logic       game_over
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_CHECK = 3'd2,
    S_FALL  = 3'd3,
    S_PROBE = 3'd4,
    S_LOCK  = 3'd5,
    S_CLEAR = 3'd6,
    S_OVER  = 3'd7
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic        r_chk, w_chk_nxt;
  logic [3:0]  r_pos_x, w_pos_x_nxt;
  logic [4:0]  r_pos_y, w_pos_y_nxt;
  logic [4:0]  r_fit_y, w_fit_y_nxt;
  logic        r_fit_req, w_fit_req_nxt;
  logic        r_clear_req, w_clear_req_nxt;
  logic        r_new_game, w_new_game_nxt;
  logic        r_spawn, w_spawn_nxt;
  logic        r_lock, w_lock_nxt;
  logic        r_game_over, w_game_over_nxt;

  // Fall period in 17-bit two's complement; a negative raw value saturates.
  logic [16:0] w_dec;
  logic [16:0] w_raw;
  logic [15:0] w_period;
  logic        w_expire;

  assign w_dec = {13'd0, level} * {1'b0, LEVEL_STEP};
  assign w_raw = {1'b0, BASE_TICKS} - w_dec;

  always_comb begin
    w_period = MIN_TICKS;
    if (!soft_drop && !w_raw[16] && (w_raw[15:0] > MIN_TICKS))
      w_period = w_raw[15:0];
  end

  assign w_expire = tick && (r_cnt >= (w_period - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 16'd0;
      r_chk       <= 1'b0;
      r_pos_x     <= 4'd0;
      r_pos_y     <= 5'd0;
      r_fit_y     <= 5'd0;
      r_fit_req   <= 1'b0;
      r_clear_req <= 1'b0;
      r_new_game  <= 1'b0;
      r_spawn     <= 1'b0;
      r_lock      <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_chk       <= w_chk_nxt;
      r_pos_x     <= w_pos_x_nxt;
      r_pos_y     <= w_pos_y_nxt;
      r_fit_y     <= w_fit_y_nxt;
      r_fit_req   <= w_fit_req_nxt;
      r_clear_req <= w_clear_req_nxt;
      r_new_game  <= w_new_game_nxt;
      r_spawn     <= w_spawn_nxt;
      r_lock      <= w_lock_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_chk_nxt       = r_chk;
    w_pos_x_nxt     = r_pos_x;
    w_pos_y_nxt     = r_pos_y;
    w_fit_y_nxt     = r_fit_y;
    w_fit_req_nxt   = r_fit_req;
    w_clear_req_nxt = r_clear_req;
    w_game_over_nxt = r_game_over;
    w_new_game_nxt  = 1'b0;
    w_spawn_nxt     = 1'b0;
    w_lock_nxt      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt    = S_SPAWN;
          w_new_game_nxt = 1'b1;
        end
      end
      S_SPAWN: begin
        w_pos_x_nxt = SPAWN_X;
        w_pos_y_nxt = SPAWN_Y;
        w_spawn_nxt = 1'b1;
        w_cnt_nxt   = 16'd0;
        w_chk_nxt   = 1'b0;
        w_state_nxt = S_CHECK;
      end
      // First CHECK cycle lets the clocked checker see the new anchor.
      S_CHECK: begin
        if (!r_chk) begin
          w_chk_nxt = 1'b1;
        end else if (game_over_in) begin
          w_state_nxt     = S_OVER;
          w_game_over_nxt = 1'b1;
        end else begin
          w_state_nxt = S_FALL;
        end
      end
      S_FALL: begin
        if (x_load)
          w_pos_x_nxt = x_new;
        if (tick) begin
          if (w_expire) begin
            w_cnt_nxt = 16'd0;
            if (r_pos_y == 5'd31) begin
              w_state_nxt = S_LOCK;
            end else begin
              w_state_nxt   = S_PROBE;
              w_fit_req_nxt = 1'b1;
              w_fit_y_nxt   = r_pos_y + 5'd1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 16'd1;
          end
        end
      end
      S_PROBE: begin
        if (fit_ack) begin
          w_fit_req_nxt = 1'b0;
          if (fit_ok) begin
            w_pos_y_nxt = r_pos_y + 5'd1;
            w_state_nxt = S_FALL;
          end else begin
            w_state_nxt = S_LOCK;
          end
        end
      end
      S_LOCK: begin
        w_lock_nxt      = 1'b1;
        w_clear_req_nxt = 1'b1;
        w_state_nxt     = S_CLEAR;
      end
      S_CLEAR: begin
        if (clear_done) begin
          w_clear_req_nxt = 1'b0;
          w_state_nxt     = S_SPAWN;
        end
      end
      S_OVER: begin
        if (start) begin
          w_state_nxt     = S_SPAWN;
          w_new_game_nxt  = 1'b1;
          w_game_over_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign state     = r_state;
  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign fit_y     = r_fit_y;
  assign fit_req   = r_fit_req;
  assign clear_req = r_clear_req;
  assign new_game  = r_new_game;
  assign spawn     = r_spawn;
  assign lock      = r_lock;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_drop_sequencer.sv
// Randomized bench for drop_sequencer: the driver pushes expected events into a
// scoreboard queue and a monitor pops and compares them as the DUT emits them.
module tb_drop_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, tick, soft_drop, x_load, game_over_in;
  logic       fit_ack, fit_ok, clear_done;
  logic [3:0] level, x_new;
  logic       fit_req, new_game, spawn, lock, clear_req, game_over;
  logic [4:0] fit_y, pos_y;
  logic [3:0] pos_x;
  logic [2:0] state;

  always #5 clk = ~clk;

  drop_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .level(level),
    .soft_drop(soft_drop), .x_load(x_load), .x_new(x_new),
    .game_over_in(game_over_in), .fit_req(fit_req), .fit_y(fit_y),
    .fit_ack(fit_ack), .fit_ok(fit_ok), .clear_done(clear_done),
    .pos_x(pos_x), .pos_y(pos_y), .new_game(new_game), .spawn(spawn),
    .lock(lock), .clear_req(clear_req), .state(state), .game_over(game_over)
  );

  localparam int K_NEWGAME = 0, K_SPAWN = 1, K_PROBE = 2, K_ACK = 3;
  localparam int K_LOCK = 4, K_OVER = 5, K_CLR = 6;

  typedef struct {
    int kind;
    int x;
    int y;
    int st;
    int ticks;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   mx = 0;
  int   my = 0;

  bit   p_fit = 1'b0, p_go = 1'b0, p_clr = 1'b0, ack_pend = 1'b0;
  int   tcnt = 0, ccnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic bail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s timeout actual=no_event expected=event (t=%0t)", nm, $time);
    summary();
    $finish;
  endtask

  task automatic push(input int kind, input int x, input int y, input int st, input int ticks);
    exp_t e;
    e.kind = kind; e.x = x; e.y = y; e.st = st; e.ticks = ticks;
    sb.push_back(e);
  endtask

  task automatic pop(input int kind, input string nm, output exp_t e, output bit got);
    checks++;
    got = 1'b0;
    e.kind = -1; e.x = 0; e.y = 0; e.st = 0; e.ticks = 0;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event actual=%0d expected=none (t=%0t)", nm, kind, $time);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind) begin
        failures++;
        $display("FAIL %s event kind actual=%0d expected=%0d (t=%0t)", nm, kind, e.kind, $time);
      end else begin
        got = 1'b1;
      end
    end
  endtask

  // Monitor: samples just after the falling edge, where inputs for the next
  // rising edge are already driven and outputs are stable.
  initial begin
    exp_t e;
    bit   got;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        ack_pend = 1'b0;
        tcnt = 0;
        ccnt = 0;
      end else begin
        if (ack_pend) begin
          pop(K_ACK, "ack", e, got);
          if (got) begin
            chk("ack_fit_req_drop", int'(fit_req), 0);
            chk("ack_pos_y", int'(pos_y), e.y);
            chk("ack_state", int'(state), e.st);
          end
          ack_pend = 1'b0;
        end
        if (new_game) begin
          pop(K_NEWGAME, "new_game", e, got);
          if (got) begin
            chk("new_game_state", int'(state), e.st);
            chk("new_game_game_over", int'(game_over), 0);
            chk("new_game_pos_x", int'(pos_x), e.x);
            chk("new_game_pos_y", int'(pos_y), e.y);
          end
        end
        if (spawn) begin
          pop(K_SPAWN, "spawn", e, got);
          if (got) begin
            chk("spawn_state", int'(state), e.st);
            chk("spawn_pos_x", int'(pos_x), e.x);
            chk("spawn_pos_y", int'(pos_y), e.y);
          end
          tcnt = 0;
        end
        if (fit_req && !p_fit) begin
          pop(K_PROBE, "probe", e, got);
          if (got) begin
            chk("probe_fit_y", int'(fit_y), e.y);
            chk("probe_pos_x", int'(pos_x), e.x);
            chk("probe_state", int'(state), e.st);
            chk("probe_ticks", tcnt, e.ticks);
          end
        end
        if (lock) begin
          pop(K_LOCK, "lock", e, got);
          if (got) begin
            chk("lock_state", int'(state), e.st);
            chk("lock_pos_y", int'(pos_y), e.y);
            chk("lock_clear_req", int'(clear_req), 1);
            chk("lock_ticks", tcnt, e.ticks);
          end
        end
        if (game_over && !p_go) begin
          pop(K_OVER, "over", e, got);
          if (got) begin
            chk("over_state", int'(state), e.st);
            chk("over_pos_x", int'(pos_x), e.x);
            chk("over_pos_y", int'(pos_y), e.y);
          end
        end
        if (!clear_req && p_clr) begin
          pop(K_CLR, "clear", e, got);
          if (got) begin
            chk("clear_req_len", ccnt, e.ticks);
            chk("clear_next_state", int'(state), e.st);
          end
          ccnt = 0;
        end
        if (clear_req) ccnt++;
        if (tick) tcnt++;
        if (fit_ack) begin
          tcnt = 0;
          ack_pend = 1'b1;
        end
      end
      p_fit = fit_req;
      p_go  = game_over;
      p_clr = clear_req;
    end
  end

  function automatic int period(input int lvl, input bit sd);
    int p;
    if (sd) return 100;
    p = 1000 - 60 * lvl;
    return (p < 100) ? 100 : p;
  endfunction

  task automatic cyc();
    @(negedge clk);
  endtask

  // which: 0 spawn, 1 fit_req, 2 lock
  task automatic wait_sig(input string nm, input int which, input int bound);
    for (int i = 0; i <= bound; i++) begin
      if ((which == 0 && spawn) || (which == 1 && fit_req) || (which == 2 && lock)) return;
      cyc();
    end
    bail(nm);
  endtask

  task automatic do_start(input int ex, input int ey);
    push(K_NEWGAME, ex, ey, 1, 0);
    push(K_SPAWN, 3, 0, 2, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_sig("spawn_after_start", 0, 6);
    mx = 3;
    my = 0;
  endtask

  // Called at the falling edge where spawn is visible (first CHECK cycle).
  task automatic check_phase(input int go);
    cyc();
    if (go != 0) push(K_OVER, mx, my, 7, 0);
    game_over_in = (go != 0);
    cyc();
    game_over_in = 1'b0;
  endtask

  // xmode: 0 quiet, 1 random moves/strays, 2 only x=7 on first tick,
  // 3 random moves plus a move on the expiry tick.
  task automatic fall_period(input int lvl, input bit sd, input int xmode);
    int p;
    level = 4'(lvl);
    soft_drop = sd;
    p = period(lvl, sd);
    for (int t = 1; t <= p; t++) begin
      if ($urandom_range(0, 1) == 1) cyc();
      tick = 1'b1;
      if (xmode == 2 && t == 1) begin
        x_load = 1'b1;
        x_new = 4'd7;
        mx = 7;
      end else if ((xmode == 1 || xmode == 3) &&
                   ($urandom_range(0, 15) == 0 || (xmode == 3 && t == p))) begin
        x_new = 4'($urandom_range(0, 15));
        x_load = 1'b1;
        mx = int'(x_new);
      end
      if ((xmode == 1 || xmode == 3) && $urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 1) == 1) start = 1'b1;
        else clear_done = 1'b1;
      end
      cyc();
      tick = 1'b0;
      x_load = 1'b0;
      start = 1'b0;
      clear_done = 1'b0;
    end
    if (my == 31) begin
      push(K_LOCK, mx, 31, 6, p);
      wait_sig("bottom_lock_wait", 2, 4);
    end else begin
      push(K_PROBE, mx, my + 1, 4, p);
      wait_sig("fit_req_wait", 1, 4);
    end
  endtask

  task automatic probe_resp(input bit ok, input int dly, input bit stray);
    for (int i = 0; i < dly; i++) begin
      if (stray) begin
        x_load = 1'b1;
        x_new = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1) tick = 1'b1;
      cyc();
      x_load = 1'b0;
      tick = 1'b0;
    end
    push(K_ACK, mx, ok ? my + 1 : my, ok ? 3 : 5, 0);
    if (ok) my++;
    fit_ack = 1'b1;
    fit_ok = ok;
    cyc();
    fit_ack = 1'b0;
    fit_ok = 1'($urandom_range(0, 1));
    if (!ok) push(K_LOCK, mx, my, 6, 0);
  endtask

  task automatic clear_phase(input int d);
    wait_sig("lock_wait", 2, 4);
    push(K_CLR, 0, 0, 1, d + 1);
    push(K_SPAWN, 3, 0, 2, 0);
    repeat (d) cyc();
    clear_done = 1'b1;
    cyc();
    clear_done = 1'b0;
    wait_sig("spawn_after_clear", 0, 4);
    mx = 3;
    my = 0;
  endtask

  task automatic over_phase(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'($urandom_range(0, 1));
      x_load = ($urandom_range(0, 3) == 0);
      x_new = 4'($urandom_range(0, 15));
      clear_done = ($urandom_range(0, 7) == 0);
      cyc();
    end
    tick = 1'b0;
    x_load = 1'b0;
    clear_done = 1'b0;
    chk("over_no_fit_req", int'(fit_req), 0);
    chk("over_state_hold", int'(state), 7);
    chk("over_game_over_hold", int'(game_over), 1);
  endtask

  initial begin
    #3000000;
    bail("watchdog");
  end

  initial begin
    bit ok;
    int go;
    rst = 1'b1; start = 1'b0; tick = 1'b0; level = 4'd0; soft_drop = 1'b0;
    x_load = 1'b0; x_new = 4'd0; game_over_in = 1'b0;
    fit_ack = 1'b0; fit_ok = 1'b0; clear_done = 1'b0;
    repeat (3) cyc();
    chk("rst_state", int'(state), 0);
    chk("rst_pos_x", int'(pos_x), 0);
    chk("rst_pos_y", int'(pos_y), 0);
    chk("rst_fit_req", int'(fit_req), 0);
    chk("rst_clear_req", int'(clear_req), 0);
    chk("rst_spawn", int'(spawn), 0);
    chk("rst_lock", int'(lock), 0);
    chk("rst_new_game", int'(new_game), 0);
    chk("rst_game_over", int'(game_over), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick = 1'($urandom_range(0, 1));
      cyc();
    end
    tick = 1'b0;

    // New game, spawn, two CHECK cycles, then FALL.
    do_start(0, 0);
    check_phase(0);
    chk("start_to_fall_state", int'(state), 3);

    // Level 0: 1000-tick periods, ack two cycles after each request.
    for (int i = 0; i < 5; i++) begin
      fall_period(0, 1'b0, 0);
      probe_resp(1'b1, 2, 1'b0);
    end
    chk("five_periods_pos_y", int'(pos_y), 5);

    // Period by level and soft drop.
    fall_period(15, 1'b0, 1);
    probe_resp(1'b1, 2, 1'b1);
    fall_period(15, 1'b1, 1);
    probe_resp(1'b1, 2, 1'b1);
    fall_period(14, 1'b0, 3);
    probe_resp(1'b1, 1, 1'b1);

    // Blocked probe: lock, seven-cycle clear, respawn.
    fall_period(15, 1'b1, 1);
    probe_resp(1'b0, 2, 1'b0);
    clear_phase(6);
    check_phase(0);

    // Lateral move in FALL, ignored move in PROBE, reset during PROBE.
    fall_period(15, 1'b1, 2);
    chk("fall_xload_pos_x", int'(pos_x), 7);
    x_load = 1'b1;
    x_new = 4'd12;
    cyc();
    x_load = 1'b0;
    chk("probe_xload_ignored", int'(pos_x), 7);
    sb.delete();
    rst = 1'b1;
    cyc();
    chk("rst_in_probe_state", int'(state), 0);
    chk("rst_in_probe_fit_req", int'(fit_req), 0);
    chk("rst_in_probe_pos_y", int'(pos_y), 0);
    rst = 1'b0;
    cyc();
    do_start(0, 0);
    check_phase(0);

    // Game over on the second CHECK cycle, then restart from OVER.
    fall_period(13, 1'b0, 1);
    probe_resp(1'b1, 0, 1'b0);
    fall_period(15, 1'b1, 1);
    probe_resp(1'b0, 3, 1'b1);
    clear_phase(0);
    check_phase(1);
    over_phase(300);
    do_start(3, 0);
    check_phase(0);

    // Fall to the bottom row: expiry at row 31 locks without a probe.
    while (my < 31) begin
      fall_period(15, 1'($urandom_range(0, 1)), 1);
      probe_resp(1'b1, $urandom_range(0, 2), 1'b0);
    end
    fall_period(15, 1'b1, 1);
    clear_phase($urandom_range(0, 8));
    check_phase(0);

    // Randomized play.
    for (int n = 0; n < 20; n++) begin
      int lvl;
      lvl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(12, 15);
      if (my == 31) begin
        fall_period(lvl, 1'($urandom_range(0, 1)), 1);
        clear_phase($urandom_range(0, 8));
        check_phase(0);
        continue;
      end
      fall_period(lvl, 1'($urandom_range(0, 1)), 1);
      ok = ($urandom_range(0, 3) != 0);
      probe_resp(ok, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if (!ok) begin
        clear_phase($urandom_range(0, 8));
        go = ($urandom_range(0, 4) == 0) ? 1 : 0;
        check_phase(go);
        if (go != 0) begin
          over_phase($urandom_range(5, 40));
          do_start(3, 0);
          check_phase(0);
        end
      end
    end

    repeat (5) cyc();
    chk("scoreboard_drained", sb.size(), 0);
    summary();
    $finish;
  end

endmodule

// File: doc/drop_sequencer.md
Name: drop_sequencer

Overview:
- Central game-flow controller for the Tetris core.
- Sequences each falling piece through spawn, game-over check, timed gravity, collision probe, lock and line clear.
- Drives the anchor position (pos_x, pos_y) that feeds the game-over checker and the collision/merge datapath.
- Samples the checker's game_over result after every spawn.

Parameters:
- SPAWN_X, 4'd3: anchor column loaded at spawn.
- SPAWN_Y, 5'd0: anchor row loaded at spawn.
- BASE_TICKS, 16'd1000: ticks per row at level 0.
- LEVEL_STEP, 16'd60: ticks removed per level.
- MIN_TICKS, 16'd100: floor on the fall period; also the soft-drop period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a new game (acted on only in IDLE or OVER)
- tick  in  1  1 kHz single-cycle time-base enable
- level  in  4  current level, 0..15
- soft_drop  in  1  while high, fall period = MIN_TICKS
- x_load  in  1  lateral move strobe
- x_new  in  4  new anchor column, accepted with x_load
- game_over_in  in  1  result from the game-over checker
- fit_req  out  1  collision probe request
- fit_y  out  5  candidate row = pos_y+1
- fit_ack  in  1  probe done (single cycle)
- fit_ok  in  1  candidate row free; valid with fit_ack
- clear_done  in  1  line-clear finished (single cycle)
- pos_x  out  4  anchor column
- pos_y  out  5  anchor row
- new_game  out  1  one-cycle pulse: clear board and score
- spawn  out  1  one-cycle pulse: load next piece into float
- lock  out  1  one-cycle pulse: merge float into board
- clear_req  out  1  line-clear request (level)
- state  out  3  FSM state, for debug/VGA overlay
- game_over  out  1  high while in OVER

Behaviour:
- All outputs are registered.
- Reset values:
  - state = IDLE (0)
  - pos_x = 0, pos_y = 0
  - fit_req, clear_req, spawn, lock, new_game, game_over = 0
  - tick counter = 0
- Reset mid-operation aborts any handshake immediately. fit_req and clear_req drop the next cycle.
- State encoding: IDLE=0, SPAWN=1, CHECK=2, FALL=3, PROBE=4, LOCK=5, CLEAR=6, OVER=7.
- IDLE:
  - start=1 → SPAWN, with new_game pulsed in the same transition cycle.
- SPAWN (1 cycle):
  - pos_x <= SPAWN_X, pos_y <= SPAWN_Y.
  - spawn=1; tick counter cleared.
  - → CHECK.
- CHECK (exactly 2 cycles):
  - Gives the clocked checker one cycle to register against the new anchor.
  - game_over_in is sampled on the 2nd cycle: 1 → OVER, 0 → FALL.
- FALL:
  - Period P = soft_drop ? MIN_TICKS : max(MIN_TICKS, BASE_TICKS − level*LEVEL_STEP).
    - Computed in 17-bit signed arithmetic; a negative result saturates to MIN_TICKS.
    - P is re-evaluated every cycle.
  - On tick, counter increments. When tick=1 and counter ≥ P−1: counter <= 0 and the expiry branch is taken.
    - pos_y == 31: → LOCK (no probe).
    - otherwise: → PROBE, with fit_req set.
  - x_load=1 updates pos_x <= x_new. It is ignored in every other state.
  - x_load on the expiry cycle still takes effect.
- PROBE:
  - fit_req held at 1 with fit_y = pos_y+1 until fit_ack.
  - On fit_ack, fit_req drops the next cycle.
    - fit_ok=1: pos_y <= pos_y+1, → FALL.
    - fit_ok=0: → LOCK.
  - tick is ignored in PROBE.
- LOCK (1 cycle): lock=1, → CLEAR.
- CLEAR:
  - clear_req=1 until clear_done, then clear_req drops and → SPAWN.
  - clear_done arriving in the same cycle clear_req rises is accepted.
- OVER:
  - game_over=1; pos_x and pos_y frozen.
  - start=1 → SPAWN, with new_game pulsed and game_over cleared in the same transition cycle.
- Stray inputs:
  - start is ignored outside IDLE and OVER.
  - Stray fit_ack outside PROBE and clear_done outside CLEAR are ignored.
- Only one of spawn, lock or new_game is high in any cycle, except that new_game and the SPAWN entry coincide as stated above.

Test Plan:
1. Reset, then start=1 for 1 cycle, game_over_in=0 → new_game pulse, spawn pulse the next cycle, pos_x=3 and pos_y=0, two CHECK cycles, then state=3.
2. level=0, soft_drop=0, fit_ack with fit_ok=1 returned 2 cycles after each fit_req → fit_req rises after the 1000th tick. fit_y=1 in the 1st probe; pos_y=1 after ack; pos_y=5 after 5 periods.
3. level=15 → P=max(100, 1000−900)=100. Then soft_drop=1 → P=100. level=14 with soft_drop=0 → P=160. Check the tick counts between successive fit_req rises.
4. Probe returns fit_ok=0 → one-cycle lock pulse, clear_req held for 7 cycles until clear_done, then spawn pulse with pos_y=0.
5. game_over_in=1 on the 2nd CHECK cycle → state=7, game_over=1, no further fit_req on ticks. start → new_game pulse, game_over=0, spawn.
6. Assert rst in PROBE with fit_req=1 → next cycle state=0, fit_req=0, pos_y=0. Also: x_load with x_new=7 in FALL sets pos_x=7, while x_load in PROBE leaves pos_x unchanged.
